// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the valid/ready pipeline register chain.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_HALF = 2'd0,
    PIPE_SKID = 2'd1,
    PIPE_PASS = 2'd2
  } pipe_mode_e;

  // Largest number of beats a chain of the given shape can hold.
  function automatic int unsigned cnt_max(int unsigned stages, pipe_mode_e mode);
    return (mode == PIPE_SKID) ? 2 * stages : stages;
  endfunction

  // Width of the occupancy counter; sized for the SKID bound in every mode so
  // the port shape does not change with the mode.
  function automatic int unsigned cnt_w(int unsigned stages, pipe_mode_e mode);
    int unsigned hi;
    hi = cnt_max(stages, mode);
    if (hi < 2 * stages) hi = 2 * stages;
    return $clog2(hi + 1);
  endfunction

endpackage

// File: rtl/pipe_hs_slice.sv
// One valid/ready register slice: HALF (1 entry), SKID (2 entries) or PASS (1 entry, comb ready).
module pipe_hs_slice
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      MODE     = 1,
  parameter logic [WIDTH-1:0] RESETVAL = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  localparam pipe_mode_e Mode = pipe_mode_e'(MODE[1:0]);

  logic             v_q, v_d;
  logic             sk_q, sk_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  assign in_xfer   = s_valid_i & s_ready_o;
  assign out_xfer  = v_q & m_ready_i;
  assign m_valid_o = v_q;
  assign m_data_o  = main_q;

  // Upstream ready: registered for HALF/SKID, combinational look-through for PASS.
  always_comb begin
    s_ready_o = ~v_q;
    if (Mode == PIPE_SKID) begin
      s_ready_o = ~sk_q;
    end else if (Mode == PIPE_PASS) begin
      s_ready_o = ~v_q | m_ready_i;
    end
  end

  // Next state for the occupancy flags and the main/skid data registers.
  always_comb begin
    v_d    = v_q;
    sk_d   = sk_q;
    main_d = main_q;
    skid_d = skid_q;
    if (Mode == PIPE_SKID) begin
      if (sk_q) begin
        // FULL: ready is low, so only draining is possible.
        if (out_xfer) begin
          sk_d   = 1'b0;
          main_d = skid_q;
        end
      end else if (v_q) begin
        if (in_xfer && !out_xfer) begin
          sk_d   = 1'b1;
          skid_d = s_data_i;
        end else if (in_xfer && out_xfer) begin
          main_d = s_data_i;
        end else if (out_xfer) begin
          v_d = 1'b0;
        end
      end else if (in_xfer) begin
        v_d    = 1'b1;
        main_d = s_data_i;
      end
    end else begin
      // HALF never sees in and out together; PASS reloads in place when it does.
      if (in_xfer) begin
        v_d    = 1'b1;
        main_d = s_data_i;
      end else if (out_xfer) begin
        v_d = 1'b0;
      end
    end
    // Flush drops every held beat and any beat arriving this cycle; data is left as is.
    if (flush_i) begin
      v_d    = 1'b0;
      sk_d   = 1'b0;
      main_d = main_q;
      skid_d = skid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q    <= 1'b0;
      sk_q   <= 1'b0;
      main_q <= RESETVAL;
      skid_q <= RESETVAL;
    end else begin
      v_q    <= v_d;
      sk_q   <= sk_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: rtl/pipe_hs_reg.sv
// Chain of STAGES valid/ready slices with a beat-occupancy counter and synchronous flush.
module pipe_hs_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      STAGES   = 1,
  parameter int unsigned      MODE     = 1,
  parameter logic [WIDTH-1:0] RESETVAL = {WIDTH{1'b0}}
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic                                                flush_i,
  input  logic                                                s_valid_i,
  output logic                                                s_ready_o,
  input  logic [WIDTH-1:0]                                    s_data_i,
  output logic                                                m_valid_o,
  input  logic                                                m_ready_i,
  output logic [WIDTH-1:0]                                    m_data_o,
  output logic [cnt_w(STAGES, pipe_mode_e'(MODE[1:0]))-1:0]   count_o
);

  localparam int unsigned CntW   = cnt_w(STAGES, pipe_mode_e'(MODE[1:0]));
  localparam int unsigned CntMax = cnt_max(STAGES, pipe_mode_e'(MODE[1:0]));

  logic             valid [STAGES+1];
  logic             ready [STAGES+1];
  logic [WIDTH-1:0] data  [STAGES+1];

  logic             s_xfer, m_xfer;
  logic [CntW-1:0]  count_q, count_d;

  assign valid[0]      = s_valid_i;
  assign data[0]       = s_data_i;
  assign ready[STAGES] = m_ready_i;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    pipe_hs_slice #(
      .WIDTH    (WIDTH),
      .MODE     (MODE),
      .RESETVAL (RESETVAL)
    ) u_slice (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .s_valid_i (valid[g]),
      .s_ready_o (ready[g]),
      .s_data_i  (data[g]),
      .m_valid_o (valid[g+1]),
      .m_ready_i (ready[g+1]),
      .m_data_o  (data[g+1])
    );
  end

  // Neither side may handshake while reset is asserted.
  assign s_ready_o = ready[0] & ~rst_i;
  assign m_valid_o = valid[STAGES] & ~rst_i;
  assign m_data_o  = data[STAGES];

  assign s_xfer  = s_valid_i & s_ready_o;
  assign m_xfer  = m_valid_o & m_ready_i;
  assign count_o = count_q;

  // Occupancy: +1 on accept only, -1 on deliver only, cleared on flush.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (s_xfer && !m_xfer) begin
      count_d = count_q + CntW'(1);
    end else if (m_xfer && !s_xfer) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  a_cnt_overflow : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(s_xfer && !m_xfer && (count_q == CntMax[CntW-1:0])));

  a_cnt_underflow : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(m_xfer && !s_xfer && (count_q == '0)));

endmodule

// File: tb/tb_pipe_hs_reg.sv
// Self-checking bench for pipe_hs_reg across SKID, HALF and PASS configurations.
module tb_pipe_hs_reg;

  localparam logic [15:0] RV = 16'h5A5A;

  logic clk, rst, flush;

  logic sk2_sv, sk2_sr, sk2_mv, sk2_mr;
  logic [15:0] sk2_sd, sk2_md;
  logic [2:0]  sk2_cnt;
  logic sk1_sv, sk1_sr, sk1_mv, sk1_mr;
  logic [15:0] sk1_sd, sk1_md;
  logic [1:0]  sk1_cnt;
  logic hf_sv, hf_sr, hf_mv, hf_mr;
  logic [15:0] hf_sd, hf_md;
  logic [1:0]  hf_cnt;
  logic ps_sv, ps_sr, ps_mv, ps_mr;
  logic [15:0] ps_sd, ps_md;
  logic [2:0]  ps_cnt;

  int checks = 0;
  int failures = 0;
  logic [15:0] q[$];

  pipe_hs_reg #(.WIDTH(16), .STAGES(2), .MODE(1), .RESETVAL(RV)) u_sk2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(sk2_sv), .s_ready_o(sk2_sr),
    .s_data_i(sk2_sd), .m_valid_o(sk2_mv), .m_ready_i(sk2_mr), .m_data_o(sk2_md),
    .count_o(sk2_cnt));
  pipe_hs_reg #(.WIDTH(16), .STAGES(1), .MODE(1), .RESETVAL(RV)) u_sk1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(sk1_sv), .s_ready_o(sk1_sr),
    .s_data_i(sk1_sd), .m_valid_o(sk1_mv), .m_ready_i(sk1_mr), .m_data_o(sk1_md),
    .count_o(sk1_cnt));
  pipe_hs_reg #(.WIDTH(16), .STAGES(1), .MODE(0), .RESETVAL(RV)) u_hf (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(hf_sv), .s_ready_o(hf_sr),
    .s_data_i(hf_sd), .m_valid_o(hf_mv), .m_ready_i(hf_mr), .m_data_o(hf_md),
    .count_o(hf_cnt));
  pipe_hs_reg #(.WIDTH(16), .STAGES(3), .MODE(2), .RESETVAL(RV)) u_ps (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(ps_sv), .s_ready_o(ps_sr),
    .s_data_i(ps_sd), .m_valid_o(ps_mv), .m_ready_i(ps_mr), .m_data_o(ps_md),
    .count_o(ps_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    sk2_sv = 1'b1; sk1_sv = 1'b1; hf_sv = 1'b1; ps_sv = 1'b1;
    sk2_mr = 1'b1; sk1_mr = 1'b1; hf_mr = 1'b1; ps_mr = 1'b1;
    sk2_sd = 16'h1111; sk1_sd = 16'h2222; hf_sd = 16'h3333; ps_sd = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({sk2_mv, sk1_mv, hf_mv, ps_mv} !== 4'b0) begin
        failures++; $display("FAIL reset_m_valid: got %b expected 0000", {sk2_mv, sk1_mv, hf_mv, ps_mv});
      end
      checks++;
      if ({sk2_sr, sk1_sr, hf_sr, ps_sr} !== 4'b0) begin
        failures++; $display("FAIL reset_s_ready: got %b expected 0000", {sk2_sr, sk1_sr, hf_sr, ps_sr});
      end
      checks++;
      if ({sk2_md, sk1_md, hf_md, ps_md} !== {4{RV}}) begin
        failures++; $display("FAIL reset_m_data: got %h expected %h", {sk2_md, sk1_md, hf_md, ps_md}, {4{RV}});
      end
      checks++;
      if ({sk2_cnt, sk1_cnt, hf_cnt, ps_cnt} !== 10'b0) begin
        failures++; $display("FAIL reset_count: got %h expected 0", {sk2_cnt, sk1_cnt, hf_cnt, ps_cnt});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    sk2_sv = 1'b0; sk1_sv = 1'b0; hf_sv = 1'b0; ps_sv = 1'b0;
    #1;
    checks++;
    if ({sk2_sr, sk1_sr, hf_sr, ps_sr} !== 4'b1111) begin
      failures++; $display("FAIL ready_after_reset: got %b expected 1111", {sk2_sr, sk1_sr, hf_sr, ps_sr});
    end
    @(negedge clk); #1;
    checks++;
    if ({sk2_mv, sk1_mv, hf_mv, ps_mv, sk2_cnt, sk1_cnt, hf_cnt, ps_cnt} !== 14'b0) begin
      failures++; $display("FAIL no_accept_in_reset: got %h expected 0",
                           {sk2_mv, sk1_mv, hf_mv, ps_mv, sk2_cnt, sk1_cnt, hf_cnt, ps_cnt});
    end
  endtask

  task automatic test_skid_stream();
    int acc = 0;
    int del = 0;
    logic exp_mv;
    sk2_mr = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      sk2_sv = (k < 16);
      sk2_sd = 16'(k + 1);
      #1;
      if (k < 16) begin
        checks++;
        if (sk2_sr !== 1'b1) begin
          failures++; $display("FAIL stream_ready k=%0d: got %b expected 1", k, sk2_sr);
        end
      end
      // Two slices: beat driven in cycle k shows at the output in cycle k+2.
      exp_mv = (k >= 2 && k <= 17);
      checks++;
      if (sk2_mv !== exp_mv) begin
        failures++; $display("FAIL stream_valid k=%0d: got %b expected %b", k, sk2_mv, exp_mv);
      end
      if (exp_mv) begin
        checks++;
        if (sk2_md !== 16'(k - 1)) begin
          failures++; $display("FAIL stream_data k=%0d: got %h expected %h", k, sk2_md, 16'(k - 1));
        end
      end
      checks++;
      if (sk2_cnt !== 3'(acc - del)) begin
        failures++; $display("FAIL stream_count k=%0d: got %0d expected %0d", k, sk2_cnt, acc - del);
      end
      if (k < 16) acc++;
      if (exp_mv) del++;
    end
    sk2_sv = 1'b0;
  endtask

  task automatic test_skid_stall();
    int sent = 0;
    int got = 0;
    logic exp_sr, exp_mv;
    q.delete();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sk1_sv = (sent < 12);
      sk1_sd = 16'($urandom);
      sk1_mr = !(k >= 4 && k < 9);
      #1;
      exp_sr = (q.size() < 2);
      exp_mv = (q.size() != 0);
      checks++;
      if (sk1_sr !== exp_sr) begin
        failures++; $display("FAIL stall_ready k=%0d: got %b expected %b", k, sk1_sr, exp_sr);
      end
      checks++;
      if (sk1_mv !== exp_mv) begin
        failures++; $display("FAIL stall_valid k=%0d: got %b expected %b", k, sk1_mv, exp_mv);
      end
      if (exp_mv) begin
        checks++;
        if (sk1_md !== q[0]) begin
          failures++; $display("FAIL stall_data k=%0d: got %h expected %h", k, sk1_md, q[0]);
        end
      end
      checks++;
      if (sk1_cnt !== 2'(q.size())) begin
        failures++; $display("FAIL stall_count k=%0d: got %0d expected %0d", k, sk1_cnt, q.size());
      end
      if (exp_mv && sk1_mr) begin
        void'(q.pop_front());
        got++;
      end
      if (sk1_sv && exp_sr) begin
        q.push_back(sk1_sd);
        sent++;
      end
    end
    sk1_sv = 1'b0; sk1_mr = 1'b1;
    checks++;
    if (got !== 12 || q.size() != 0) begin
      failures++; $display("FAIL stall_delivered: got %0d expected 12", got);
    end
  endtask

  task automatic test_half();
    int n_out = 0;
    logic exp_sr, exp_mv;
    q.delete();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hf_sv = 1'b1; hf_mr = 1'b1; hf_sd = 16'($urandom);
      #1;
      exp_sr = (q.size() == 0);
      exp_mv = (q.size() == 1);
      checks++;
      if ({hf_sr, hf_mv} !== {exp_sr, exp_mv}) begin
        failures++; $display("FAIL half_handshake k=%0d: got %b expected %b", k, {hf_sr, hf_mv},
                             {exp_sr, exp_mv});
      end
      if (exp_mv) begin
        checks++;
        if (hf_md !== q[0]) begin
          failures++; $display("FAIL half_data k=%0d: got %h expected %h", k, hf_md, q[0]);
        end
      end
      checks++;
      if (hf_cnt !== 2'(q.size())) begin
        failures++; $display("FAIL half_count k=%0d: got %0d expected %0d", k, hf_cnt, q.size());
      end
      if (exp_mv) begin
        void'(q.pop_front());
        n_out++;
      end else if (exp_sr) begin
        q.push_back(hf_sd);
      end
    end
    @(negedge clk);
    hf_sv = 1'b0;
    checks++;
    if (n_out !== 10) begin
      failures++; $display("FAIL half_throughput: got %0d expected 10", n_out);
    end
  endtask

  task automatic test_pass_random();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic exp_sr;
    q.delete();
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      ps_sv = (sent < 1000) && ($urandom_range(0, 1) == 1);
      ps_sd = 16'($urandom);
      ps_mr = ($urandom_range(0, 1) == 1);
      #1;
      // Some slice is free unless all three hold a beat; then ready follows downstream.
      exp_sr = (q.size() < 3) || ps_mr;
      checks++;
      if (ps_sr !== exp_sr) begin
        failures++; $display("FAIL pass_ready cyc=%0d: got %b expected %b", cyc, ps_sr, exp_sr);
      end
      checks++;
      if (ps_cnt !== 3'(q.size())) begin
        failures++; $display("FAIL pass_count cyc=%0d: got %0d expected %0d", cyc, ps_cnt, q.size());
      end
      if (ps_mv) begin
        checks++;
        if (q.size() == 0 || ps_md !== q[0]) begin
          failures++; $display("FAIL pass_data cyc=%0d: got %h expected %h (held %0d)", cyc, ps_md,
                               (q.size() != 0) ? q[0] : 16'h0, q.size());
        end
      end
      if (ps_mv && ps_mr && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      if (ps_sv && exp_sr) begin
        q.push_back(ps_sd);
        sent++;
      end
      cyc++;
    end
    ps_sv = 1'b0; ps_mr = 1'b1;
    checks++;
    if (got !== 1000) begin
      failures++; $display("FAIL pass_delivered: got %0d expected 1000", got);
    end
  endtask

  task automatic test_flush();
    q.delete();
    sk2_mr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sk2_sv = 1'b1;
      sk2_sd = 16'h0100 | 16'($urandom_range(0, 255));
    end
    @(negedge clk);
    sk2_sv = 1'b1; sk2_sd = 16'h00AA; flush = 1'b1;
    #1;
    checks++;
    if ({sk2_cnt, sk2_sr, sk2_mv} !== {3'd3, 1'b1, 1'b1}) begin
      failures++; $display("FAIL flush_pre: got cnt=%0d rdy=%b vld=%b expected cnt=3 rdy=1 vld=1",
                           sk2_cnt, sk2_sr, sk2_mv);
    end
    @(negedge clk);
    flush = 1'b0; sk2_sv = 1'b0; sk2_mr = 1'b1;
    #1;
    checks++;
    if ({sk2_mv, sk2_cnt} !== 4'b0) begin
      failures++; $display("FAIL flush_post: got vld=%b cnt=%0d expected 0 0", sk2_mv, sk2_cnt);
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      sk2_sv = (k < 9) && ($urandom_range(0, 1) == 1);
      sk2_sd = 16'h0100 | 16'($urandom_range(0, 255));
      sk2_mr = ($urandom_range(0, 3) != 0);
      if (k >= 9) sk2_mr = 1'b1;
      #1;
      if (sk2_mv) begin
        checks++;
        if (q.size() == 0 || sk2_md !== q[0] || sk2_md === 16'h00AA) begin
          failures++; $display("FAIL flush_data k=%0d: got %h expected %h", k, sk2_md,
                               (q.size() != 0) ? q[0] : 16'h0);
        end
      end
      checks++;
      if (sk2_cnt !== 3'(q.size())) begin
        failures++; $display("FAIL flush_count k=%0d: got %0d expected %0d", k, sk2_cnt, q.size());
      end
      if (sk2_mv && sk2_mr && q.size() != 0) void'(q.pop_front());
      if (sk2_sv && sk2_sr) q.push_back(sk2_sd);
    end
    sk2_sv = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL flush_drain: got %0d held expected 0", q.size());
    end
  endtask

  task automatic test_reset_midstream();
    sk1_mr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sk1_sv = 1'b1; sk1_sd = 16'h0F00 | 16'(k);
    end
    @(negedge clk);
    rst = 1'b1; sk1_mr = 1'b1; sk1_sd = 16'h0BAD;
    #1;
    checks++;
    if ({sk1_mv, sk1_sr} !== 2'b00) begin
      failures++; $display("FAIL midreset_handshake: got %b expected 00", {sk1_mv, sk1_sr});
    end
    @(negedge clk);
    rst = 1'b0; sk1_sv = 1'b0;
    #1;
    checks++;
    if ({sk1_mv, sk1_cnt, sk1_md} !== {1'b0, 2'd0, RV}) begin
      failures++; $display("FAIL midreset_state: got vld=%b cnt=%0d data=%h expected 0 0 %h",
                           sk1_mv, sk1_cnt, sk1_md, RV);
    end
  endtask

  initial begin
    test_reset();
    test_skid_stream();
    test_skid_stall();
    test_half();
    test_pass_random();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
